feinv_seq: RTL and testbench

- Computes the field inverse out = a^(p-2) mod p, with p = 2^255-19.
- Uses left-to-right square-and-multiply over a hard-wired exponent.
- This block is the initiator side of the femul start/done interface. It does no arithmetic itself: it issues start/operand requests to an external femul and consumes its done/out responses.
- Sits above femul in the point-arithmetic datapath, for example for the final affine conversion.

---
 rtl/feinv_seq.sv | 136 +++++++++++++
 tb/tb_feinv_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/feinv_seq.sv
// Field inverse a^(p-2) mod p, p = 2^255-19, by left-to-right square-and-multiply.
// All arithmetic is delegated to an external femul over a start/done handshake.
module feinv_seq (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [254:0] a,
  output logic         busy,
  output logic         done,
  output logic [254:0] out,
  output logic         mul_start,
  output logic [254:0] mul_a,
  output logic [254:0] mul_b,
  input  logic         mul_done,
  input  logic [254:0] mul_out
);

  typedef enum logic [2:0] {IDLE, SQ_ISSUE, SQ_WAIT, MU_ISSUE, MU_WAIT, FIN} state_t;

  state_t       state_q, state_d;
  logic [254:0] base_q, base_d;
  logic [254:0] acc_q, acc_d;
  logic [254:0] out_q, out_d;
  logic [7:0]   idx_q, idx_d;
  logic         busy_q, busy_d;
  logic         mdone_q;
  logic         mul_rise;
  logic         last_bit;
  state_t       step_state;
  logic [7:0]   step_idx;

  // Exponent p-2 = 2^255-21: ones from bit 5 up, low bits 0_1011.
  function automatic logic e_bit(input logic [7:0] i);
    if (i >= 8'd5) return 1'b1;
    case (i)
      8'd3, 8'd1, 8'd0: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

  assign mul_rise   = mul_done & ~mdone_q;
  assign last_bit   = (idx_q == 8'd0);
  assign step_state = last_bit ? FIN : SQ_ISSUE;
  assign step_idx   = last_bit ? idx_q : idx_q - 8'd1;
  assign busy       = busy_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      idx_q   <= 8'd253;
      busy_q  <= 1'b0;
      mdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      mdone_q <= mul_done;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    acc_d     = acc_q;
    out_d     = out_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    mul_start = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    done      = 1'b0;
    out       = out_q;
    case (state_q)
      IDLE: begin
        // Loading acc with a accounts for the top exponent bit.
        if (start) begin
          base_d  = a;
          acc_d   = a;
          idx_d   = 8'd253;
          busy_d  = 1'b1;
          state_d = SQ_ISSUE;
        end
      end
      SQ_ISSUE: begin
        mul_a     = acc_q;
        mul_b     = acc_q;
        mul_start = 1'b1;
        state_d   = SQ_WAIT;
      end
      SQ_WAIT: begin
        mul_a = acc_q;
        mul_b = acc_q;
        if (mul_rise) begin
          acc_d = mul_out;
          if (e_bit(idx_q)) begin
            state_d = MU_ISSUE;
          end else begin
            state_d = step_state;
            idx_d   = step_idx;
          end
        end
      end
      MU_ISSUE: begin
        mul_a     = acc_q;
        mul_b     = base_q;
        mul_start = 1'b1;
        state_d   = MU_WAIT;
      end
      MU_WAIT: begin
        mul_a = acc_q;
        mul_b = base_q;
        if (mul_rise) begin
          acc_d   = mul_out;
          state_d = step_state;
          idx_d   = step_idx;
        end
      end
      FIN: begin
        // Result is presented combinationally so it is valid with done.
        done    = 1'b1;
        out     = acc_q;
        out_d   = acc_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_feinv_seq.sv
// Bench for feinv_seq: behavioural femul with programmable latency, a per-cycle
// compare process (protocol, busy/done, result via out*a == 1 mod p) and directed ops.
module tb_feinv_seq;

  localparam logic [254:0] P    = {255{1'b1}} - 255'd18;
  localparam logic [254:0] INV2 = (255'd1 << 254) - 255'd9;
  localparam logic [254:0] A_T  =
    255'd25728561913544074806655338655832537372072648408242416352266576543536686506277;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [254:0] a = '0;
  logic         busy, done, mul_start;
  logic [254:0] out, mul_a, mul_b;
  logic         mul_done = 1'b0;
  logic [254:0] mul_out = '0;

  int total = 0;
  int bad   = 0;

  feinv_seq dut (
    .clock(clock), .reset(reset), .start(start), .a(a),
    .busy(busy), .done(done), .out(out),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_out(mul_out)
  );

  always #5 clock = ~clock;

  function automatic logic [254:0] modmul(input logic [254:0] x, input logic [254:0] y);
    logic [509:0] pr;
    logic [260:0] t;
    pr = 510'(x) * 510'(y);
    t  = 261'(pr[254:0]) + 261'(pr[509:255]) * 261'd19;
    t  = 261'(t[254:0]) + 261'(t[260:255]) * 261'd19;
    while (t >= 261'(P)) t = t - 261'(P);
    return t[254:0];
  endfunction

  task automatic chk(input string nm, input logic [254:0] act, input logic [254:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural femul: product appears as a one-cycle done pulse L cycles after start.
  int           fm_lat = 3;
  int           fm_cnt = 0;
  logic [254:0] fm_a = '0, fm_b = '0;
  always @(posedge clock) begin
    mul_done <= 1'b0;
    if (mul_start) begin
      fm_cnt <= fm_lat;
      fm_a   <= mul_a;
      fm_b   <= mul_b;
    end else if (fm_cnt > 1) begin
      fm_cnt <= fm_cnt - 1;
    end else if (fm_cnt == 1) begin
      fm_cnt   <= 0;
      mul_done <= 1'b1;
      mul_out  <= modmul(fm_a, fm_b);
    end
  end

  // Per-cycle compare against the bench's view of the operation.
  logic         exp_busy = 1'b0, prev_done = 1'b0, prev_mdone = 1'b0, outst = 1'b0;
  logic [254:0] op_a = '0, hold_a = '0, hold_b = '0, exp_out = '0;
  int           nreq = 0;
  always @(negedge clock) begin
    if (reset) begin
      chk("reset_outputs", 255'({busy, done, mul_start, |mul_a, |mul_b, |out}), '0);
      exp_busy  = 1'b0;
      outst     = 1'b0;
      nreq      = 0;
      exp_out   = '0;
      prev_done = 1'b0;
    end else begin
      chk("busy", 255'(busy), 255'(exp_busy));
      if (mul_done && !prev_mdone && outst) outst = 1'b0;
      if (outst) begin
        chk("mul_a_hold", mul_a, hold_a);
        chk("mul_b_hold", mul_b, hold_b);
      end
      if (mul_start) begin
        chk("start_outstanding", 255'(outst), '0);
        chk("start_when_busy", 255'(exp_busy), 255'(1));
        outst  = 1'b1;
        hold_a = mul_a;
        hold_b = mul_b;
        nreq++;
      end
      if (done) begin
        chk("done_single", 255'(prev_done), '0);
        chk("done_when_busy", 255'(exp_busy), 255'(1));
        chk("req_count", 255'(nreq), 255'(506));
        chk("out_range", 255'(out < P), 255'(1));
        if (op_a == '0) chk("inv_zero", out, '0);
        else            chk("inv_prod", modmul(out, op_a), 255'(1));
        exp_out  = out;
        exp_busy = 1'b0;
      end else begin
        chk("out_hold", out, exp_out);
      end
      if (start && !exp_busy && !done) begin
        exp_busy = 1'b1;
        op_a     = a;
        nreq     = 0;
      end
      prev_done = done;
    end
    prev_mdone = mul_done;
  end

  task automatic do_op(input logic [254:0] x, input int lat, input bit lit_en,
                       input logic [254:0] lit, input int inj);
    int cyc;
    bit seen;
    fm_lat = lat;
    @(posedge clock); #1 start = 1'b1; a = x;
    @(posedge clock); #1 start = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    for (int k = 0; k < 506 * (lat + 2) + 200 && !seen; k++) begin
      @(negedge clock);
      if (busy) cyc++;
      if (k == inj) begin
        start = 1'b1;
        a     = 255'd5;
      end else if (start) begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        if (lit_en) chk("out_literal", out, lit);
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: no done for a=%0h latency=%0d", x, lat);
    end else begin
      chk("busy_cycles", 255'(cyc), 255'(506 * (lat + 2) + 1));
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    chk("model_inv2", modmul(INV2, 255'd2), 255'(1));
    chk("model_pm1", modmul(P - 255'd1, P - 255'd1), 255'(1));

    do_op(255'd2, 3, 1'b1, INV2, -1);
    do_op(255'd1, 1, 1'b1, 255'd1, -1);
    do_op(255'd0, 1, 1'b1, 255'd0, -1);
    do_op(P - 255'd1, 1, 1'b1, P - 255'd1, -1);
    do_op(255'd1, 3, 1'b1, 255'd1, -1);
    do_op(255'd0, 3, 1'b1, 255'd0, -1);
    do_op(P - 255'd1, 3, 1'b1, P - 255'd1, -1);
    do_op(P - 255'd1, 40, 1'b1, P - 255'd1, -1);
    do_op(A_T, 3, 1'b0, '0, -1);
    do_op(255'd2, 3, 1'b1, INV2, 50);

    // Abort after the 100th request has been issued, with its done still pending.
    fm_lat = 3;
    @(posedge clock); #1 start = 1'b1; a = 255'd7;
    @(posedge clock); #1 start = 1'b0;
    n = 0;
    for (int k = 0; k < 5000 && n < 100; k++) begin
      @(negedge clock);
      if (mul_start) n++;
    end
    if (n < 100) begin
      total++;
      bad++;
      $display("FAIL reset_setup: only %0d requests seen", n);
    end
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    do_op(255'd2, 3, 1'b1, INV2, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
